// File: rtl/accumulator_sequencer_if.sv
// Bus bundle for accumulator_sequencer: control, sample stream, datapath and readout.
// ACCUM_SEQ_TIMEOUT_EN adds the o_timeout pulse.
interface accumulator_sequencer_if #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 32,
    parameter int PASS_W    = 4
);
    localparam int AW = $clog2(RAM_DEPTH);

    logic                 i_start;
    logic                 i_abort;
    logic [PASS_W-1:0]    i_num_passes;
    logic                 i_trigger;
    logic                 i_smp_valid;
    logic [RAM_WIDTH-1:0] i_smp_data;
    logic                 o_acc_wr_valid;
    logic [RAM_WIDTH-1:0] o_acc_wr_data;
    logic [AW-1:0]        o_acc_wr_addr;
    logic                 o_acc_first;
    logic                 o_acc_rd_en;
    logic [AW-1:0]        o_acc_rd_addr;
    logic [RAM_WIDTH-1:0] i_acc_rd_data;
    logic                 o_out_valid;
    logic [RAM_WIDTH-1:0] o_out_data;
    logic                 o_out_last;
    logic                 i_out_ready;
    logic                 o_busy;
    logic                 o_done;
    logic [PASS_W-1:0]    o_pass_cnt;
`ifdef ACCUM_SEQ_TIMEOUT_EN
    logic                 o_timeout;
`endif

    modport slave (
        input  i_start, i_abort, i_num_passes, i_trigger, i_smp_valid, i_smp_data,
               i_acc_rd_data, i_out_ready,
        output o_acc_wr_valid, o_acc_wr_data, o_acc_wr_addr, o_acc_first,
               o_acc_rd_en, o_acc_rd_addr, o_out_valid, o_out_data, o_out_last,
`ifdef ACCUM_SEQ_TIMEOUT_EN
               o_timeout,
`endif
               o_busy, o_done, o_pass_cnt
    );

    modport master (
        output i_start, i_abort, i_num_passes, i_trigger, i_smp_valid, i_smp_data,
               i_acc_rd_data, i_out_ready,
        input  o_acc_wr_valid, o_acc_wr_data, o_acc_wr_addr, o_acc_first,
               o_acc_rd_en, o_acc_rd_addr, o_out_valid, o_out_data, o_out_last,
`ifdef ACCUM_SEQ_TIMEOUT_EN
               o_timeout,
`endif
               o_busy, o_done, o_pass_cnt
    );
endinterface

// File: rtl/accumulator_sequencer.sv
// Multi-pass trigger-aligned accumulation controller with valid/ready readout.
// ACCUM_SEQ_TIMEOUT_EN enables an ARM watchdog that aborts after TIMEOUT_CYC cycles.
module accumulator_sequencer #(
    parameter int RAM_WIDTH   = 32,
    parameter int RAM_DEPTH   = 32,
    parameter int MAX_PASSES  = 8
`ifdef ACCUM_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    accumulator_sequencer_if.slave  bus
);
    localparam int PASS_W = $clog2(MAX_PASSES) + 1;
    localparam int AW     = $clog2(RAM_DEPTH);
    localparam logic [AW-1:0]     LAST_BIN = AW'(RAM_DEPTH - 1);
    localparam logic [PASS_W-1:0] MAX_P    = PASS_W'(MAX_PASSES);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [PASS_W-1:0]    npass_q, npass_d;
    logic [PASS_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [AW-1:0]        bin_q, bin_d;
    logic                 wr_valid_q, wr_valid_d;
    logic                 wr_first_q, wr_first_d;
    logic [RAM_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [AW-1:0]        rd_bin_q, rd_bin_d;
    logic                 rd_done_q, rd_done_d;
    logic                 pend_q, pend_d;
    logic                 pend_last_q, pend_last_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [RAM_WIDTH-1:0] out_data_q, out_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 skid_last_q, skid_last_d;
    logic [RAM_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                 pop, fetch, smp_take;
`ifdef ACCUM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0]        arm_cnt_q, arm_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        npass_d      = npass_q;
        pass_cnt_d   = pass_cnt_q;
        bin_d        = bin_q;
        wr_valid_d   = 1'b0;
        wr_first_d   = wr_first_q;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        rd_bin_d     = rd_bin_q;
        rd_done_d    = rd_done_q;
        pend_d       = 1'b0;
        pend_last_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        pop          = out_valid_q && bus.i_out_ready;
        fetch        = 1'b0;
        smp_take     = 1'b0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
        arm_cnt_d    = '0;
        timeout_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    npass_d    = (bus.i_num_passes == '0 || bus.i_num_passes > MAX_P)
                                 ? MAX_P : bus.i_num_passes;
                    pass_cnt_d = '0;
                    bin_d      = '0;
                    rd_bin_d   = '0;
                    rd_done_d  = 1'b0;
                    state_d    = S_ARM;
                end
            end
            S_ARM: begin
                if (bus.i_trigger) begin
                    state_d  = S_CAPTURE;
                    smp_take = bus.i_smp_valid;
                end
`ifdef ACCUM_SEQ_TIMEOUT_EN
                else if (arm_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
`endif
            end
            S_CAPTURE: smp_take = bus.i_smp_valid;
            S_DRAIN: begin
                // The skid check guarantees room for the word already in flight from the RAM.
                fetch = !rd_done_q && (!out_valid_q || pop) && !skid_valid_q && !bus.i_abort;
                if (pop && out_last_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (smp_take) begin
            wr_valid_d = 1'b1;
            wr_data_d  = bus.i_smp_data;
            wr_addr_d  = bin_q;
            wr_first_d = (pass_cnt_q == '0);
            if (bin_q == LAST_BIN) begin
                bin_d      = '0;
                pass_cnt_d = pass_cnt_q + 1'b1;
                state_d    = (pass_cnt_d == npass_q) ? S_DRAIN : S_ARM;
            end else begin
                bin_d = bin_q + 1'b1;
            end
        end

        if (fetch) begin
            pend_d      = 1'b1;
            pend_last_d = (rd_bin_q == LAST_BIN);
            if (rd_bin_q == LAST_BIN) rd_done_d = 1'b1;
            else                      rd_bin_d  = rd_bin_q + 1'b1;
        end

        if (pop) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (pend_q) begin
                out_data_d = bus.i_acc_rd_data;
                out_last_d = pend_last_q;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (pend_q) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.i_acc_rd_data;
                out_last_d  = pend_last_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.i_acc_rd_data;
                skid_last_d  = pend_last_q;
            end
        end

        if (bus.i_abort) begin
            state_d      = S_IDLE;
            wr_valid_d   = 1'b0;
            pend_d       = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            skid_valid_d = 1'b0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
            timeout_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            npass_q      <= '0;
            pass_cnt_q   <= '0;
            bin_q        <= '0;
            wr_valid_q   <= 1'b0;
            wr_first_q   <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            rd_bin_q     <= '0;
            rd_done_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
            arm_cnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            npass_q      <= npass_d;
            pass_cnt_q   <= pass_cnt_d;
            bin_q        <= bin_d;
            wr_valid_q   <= wr_valid_d;
            wr_first_q   <= wr_first_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            rd_bin_q     <= rd_bin_d;
            rd_done_q    <= rd_done_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
`ifdef ACCUM_SEQ_TIMEOUT_EN
            arm_cnt_q    <= arm_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign bus.o_acc_wr_valid = wr_valid_q;
    assign bus.o_acc_wr_data  = wr_data_q;
    assign bus.o_acc_wr_addr  = wr_addr_q;
    assign bus.o_acc_first    = wr_first_q && wr_valid_q;
    assign bus.o_acc_rd_en    = fetch;
    assign bus.o_acc_rd_addr  = rd_bin_q;
    assign bus.o_out_valid    = out_valid_q;
    assign bus.o_out_data     = out_data_q;
    assign bus.o_out_last     = out_valid_q && out_last_q;
    assign bus.o_busy         = (state_q != S_IDLE);
    assign bus.o_done         = (state_q == S_DONE);
    assign bus.o_pass_cnt     = pass_cnt_q;
`ifdef ACCUM_SEQ_TIMEOUT_EN
    assign bus.o_timeout      = timeout_q;
`endif
endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer with a behavioural accumulator RAM.
// ACCUM_SEQ_TIMEOUT_EN additionally exercises the ARM watchdog.
module tb_accumulator_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    accumulator_sequencer_if #(.RAM_WIDTH(32), .RAM_DEPTH(32), .PASS_W(4)) bus ();

    accumulator_sequencer #(.RAM_WIDTH(32), .RAM_DEPTH(32), .MAX_PASSES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath stand-in: first-pass writes overwrite, later passes add; 1-cycle read latency.
    logic [31:0] ram [32];
    always @(posedge clk) begin
        if (bus.o_acc_wr_valid)
            ram[bus.o_acc_wr_addr] <= bus.o_acc_first ? bus.o_acc_wr_data
                                                      : ram[bus.o_acc_wr_addr] + bus.o_acc_wr_data;
        if (bus.o_acc_rd_en) bus.i_acc_rd_data <= ram[bus.o_acc_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [3:0] n);
        bus.i_num_passes = n;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start      = 1'b0;
        check("start_busy", 32'(bus.o_busy), 32'd1);
    endtask

    // One record: sample k carries mul*k+add; retrig re-pulses i_trigger at that bin.
    task automatic run_pass(input int pass, input logic [31:0] mul, input logic [31:0] add,
                            input bit gappy, input int retrig);
        int   k   = 0;
        int   cyc = 0;
        logic v;
        while (k < 32 && cyc < 200) begin
            v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_trigger   = (cyc == 0) || (k == retrig);
            bus.i_smp_valid = v;
            bus.i_smp_data  = mul * k + add;
            tick();
            cyc++;
            check("wr_valid", 32'(bus.o_acc_wr_valid), 32'(v));
            if (v) begin
                check("wr_addr",  32'(bus.o_acc_wr_addr), k);
                check("wr_data",  bus.o_acc_wr_data, mul * k + add);
                check("wr_first", 32'(bus.o_acc_first), 32'(pass == 0));
                k++;
            end
        end
        bus.i_trigger   = 1'b0;
        bus.i_smp_valid = 1'b0;
        check("pass_bins", k, 32);
        check("pass_cnt", 32'(bus.o_pass_cnt), pass + 1);
    endtask

    // Expect word k == mul*k+add, o_out_last on k==31, then the o_done pulse.
    task automatic drain(input logic [31:0] mul, input logic [31:0] add, input bit rnd);
        int          k    = 0;
        int          cyc  = 0;
        logic        held = 1'b0;
        logic [31:0] hd   = '0;
        while (k < 32 && cyc < 500) begin
            bus.i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                check("stall_valid", 32'(bus.o_out_valid), 32'd1);
                check("stall_data",  bus.o_out_data, hd);
            end
            if (!rnd && k > 0) check("no_bubble", 32'(bus.o_out_valid), 32'd1);
            held = 1'b0;
            if (bus.o_out_valid) begin
                if (bus.i_out_ready) begin
                    check("rd_data", bus.o_out_data, mul * k + add);
                    check("rd_last", 32'(bus.o_out_last), 32'(k == 31));
                    k++;
                end else begin
                    held = 1'b1;
                    hd   = bus.o_out_data;
                end
            end
            tick();
            cyc++;
        end
        bus.i_out_ready = 1'b0;
        check("drain_count", k, 32);
        check("done_pulse", 32'(bus.o_done), 32'd1);
        tick();
        check("done_clear", 32'(bus.o_done), 32'd0);
        check("idle_after", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_num_passes = '0;
        bus.i_trigger    = 1'b0;
        bus.i_smp_valid  = 1'b0;
        bus.i_smp_data   = '0;
        bus.i_out_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_busy",     32'(bus.o_busy), 32'd0);
        check("rst_done",     32'(bus.o_done), 32'd0);
        check("rst_wr_valid", 32'(bus.o_acc_wr_valid), 32'd0);
        check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("rst_rd_en",    32'(bus.o_acc_rd_en), 32'd0);
        check("rst_pass_cnt", 32'(bus.o_pass_cnt), 32'd0);

        // Trigger in IDLE does nothing.
        bus.i_trigger = 1'b1; bus.i_smp_valid = 1'b1;
        tick();
        bus.i_trigger = 1'b0; bus.i_smp_valid = 1'b0;
        check("idle_trig_busy", 32'(bus.o_busy), 32'd0);
        check("idle_trig_wr",   32'(bus.o_acc_wr_valid), 32'd0);

        // N=3, samples = bin: readout 3k; a start while busy and a mid-record trigger are ignored.
        start(4'd3);
        repeat (3) tick();
        run_pass(0, 32'd1, 32'd0, 1'b0, -1);
        bus.i_num_passes = 4'd1; bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("busy_start_pcnt", 32'(bus.o_pass_cnt), 32'd1);
        run_pass(1, 32'd1, 32'd0, 1'b0, 5);
        run_pass(2, 32'd1, 32'd0, 1'b0, -1);
        drain(32'd3, 32'd0, 1'b0);

        // Pass 0 overwrites leftover sums; two all-ones passes wrap to 0xFFFFFFFE.
        start(4'd1);
        run_pass(0, 32'd0, 32'hFFFF_FFFF, 1'b0, -1);
        drain(32'd0, 32'hFFFF_FFFF, 1'b0);
        start(4'd2);
        run_pass(0, 32'd0, 32'hFFFF_FFFF, 1'b0, -1);
        run_pass(1, 32'd0, 32'hFFFF_FFFF, 1'b0, -1);
        drain(32'd0, 32'hFFFF_FFFE, 1'b0);

        // Gappy samples, then randomly stalled readout: 2k+200.
        start(4'd2);
        run_pass(0, 32'd1, 32'd100, 1'b1, -1);
        run_pass(1, 32'd1, 32'd100, 1'b1, -1);
        drain(32'd2, 32'd200, 1'b1);

        // N=0 clamps to 8 passes of constant 1.
        start(4'd0);
        for (int p = 0; p < 8; p++) run_pass(p, 32'd0, 32'd1, 1'b0, -1);
        drain(32'd0, 32'd8, 1'b0);

        // Abort at bin 10 of pass 1, then a clean single-pass run.
        start(4'd3);
        run_pass(0, 32'd1, 32'd0, 1'b0, -1);
        for (int k = 0; k < 10; k++) begin
            bus.i_trigger = (k == 0); bus.i_smp_valid = 1'b1; bus.i_smp_data = 32'(k);
            tick();
        end
        bus.i_trigger = 1'b0; bus.i_abort = 1'b1; bus.i_smp_data = 32'd10;
        tick();
        bus.i_abort = 1'b0; bus.i_smp_valid = 1'b0;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_wr",   32'(bus.o_acc_wr_valid), 32'd0);
        start(4'd1);
        check("restart_pcnt", 32'(bus.o_pass_cnt), 32'd0);
        run_pass(0, 32'd1, 32'd7, 1'b0, -1);
        drain(32'd1, 32'd7, 1'b1);

`ifdef ACCUM_SEQ_TIMEOUT_EN
        start(4'd1);
        repeat (1023) tick();
        check("to_pre_busy",    32'(bus.o_busy), 32'd1);
        check("to_pre_timeout", 32'(bus.o_timeout), 32'd0);
        tick();
        check("to_timeout", 32'(bus.o_timeout), 32'd1);
        check("to_busy",    32'(bus.o_busy), 32'd0);
        check("to_done",    32'(bus.o_done), 32'd0);
        tick();
        check("to_pulse_end", 32'(bus.o_timeout), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
